// File: rtl/ysyx_22040237_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: widths, FSM encoding, master IDs
// and the latched request payload.
package ysyx_22040237_mem_arb_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned WMASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_REQ_IFU  = 3'd1,
    ARB_REQ_LSU  = 3'd2,
    ARB_WAIT_IFU = 3'd3,
    ARB_WAIT_LSU = 3'd4
  } arb_state_e;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_id_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               wen;
    logic [DATA_W-1:0]  wdata;
    logic [WMASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22040237_mem_arb_if.sv
// Bundle of requester (IFU/LSU) and memory-side signals around the arbiter.
// slave = arbiter view, master = surrounding core/memory view.
interface ysyx_22040237_mem_arb_if;
  import ysyx_22040237_mem_arb_pkg::*;

  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [ADDR_W-1:0]  ifu_addr;
  logic               ifu_rsp_valid;
  logic [DATA_W-1:0]  ifu_rsp_data;

  logic               lsu_req_valid;
  logic               lsu_req_ready;
  logic [ADDR_W-1:0]  lsu_addr;
  logic               lsu_wen;
  logic [DATA_W-1:0]  lsu_wdata;
  logic [WMASK_W-1:0] lsu_wmask;
  logic               lsu_rsp_valid;
  logic [DATA_W-1:0]  lsu_rsp_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_wen;
  logic [DATA_W-1:0]  mem_wdata;
  logic [WMASK_W-1:0] mem_wmask;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rsp_data;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/ysyx_22040237_mem_req_reg.sv
// Load-enabled register holding the granted memory request, cleared by async reset.
module ysyx_22040237_mem_req_reg
  import ysyx_22040237_mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  mem_req_t d,
  output mem_req_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ysyx_22040237_mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory arbiter: one outstanding transaction,
// grant held until the memory response is routed back to its owner.
module ysyx_22040237_mem_arb
  import ysyx_22040237_mem_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040237_mem_arb_if.slave   bus
);

  arb_state_e state_q, state_d;
  logic       last_lsu_q, last_lsu_d;
  logic       sel_ifu_c, sel_lsu_c, load_c;
  mem_req_t   req_d_c, req_q;
  logic       in_wait_c;
  mst_id_e    owner_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      last_lsu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  // Next state, arbitration and request capture
  always_comb begin
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    sel_ifu_c  = 1'b0;
    sel_lsu_c  = 1'b0;
    load_c     = 1'b0;
    req_d_c    = '0;
    unique case (state_q)
      ARB_IDLE: begin
        // LSU wins unless it also won last time and IFU is waiting
        sel_lsu_c = bus.lsu_req_valid & ~(last_lsu_q & bus.ifu_req_valid);
        sel_ifu_c = bus.ifu_req_valid & ~sel_lsu_c;
        if (sel_lsu_c) begin
          load_c        = 1'b1;
          req_d_c.addr  = bus.lsu_addr;
          req_d_c.wen   = bus.lsu_wen;
          req_d_c.wdata = bus.lsu_wdata;
          req_d_c.wmask = bus.lsu_wen ? bus.lsu_wmask : '0;
          last_lsu_d    = 1'b1;
          state_d       = ARB_REQ_LSU;
        end else if (sel_ifu_c) begin
          load_c        = 1'b1;
          req_d_c.addr  = bus.ifu_addr;
          last_lsu_d    = 1'b0;
          state_d       = ARB_REQ_IFU;
        end
      end
      ARB_REQ_IFU:  if (bus.mem_req_ready) state_d = ARB_WAIT_IFU;
      ARB_REQ_LSU:  if (bus.mem_req_ready) state_d = ARB_WAIT_LSU;
      ARB_WAIT_IFU: if (bus.mem_rsp_valid) state_d = ARB_IDLE;
      ARB_WAIT_LSU: if (bus.mem_rsp_valid) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  ysyx_22040237_mem_req_reg u_req_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .d    (req_d_c),
    .q    (req_q)
  );

  assign in_wait_c = (state_q == ARB_WAIT_IFU) || (state_q == ARB_WAIT_LSU);
  assign owner_c   = (state_q == ARB_WAIT_LSU) ? MST_LSU : MST_IFU;

  // Readies are held low while reset is asserted so no handshake is seen then
  assign bus.ifu_req_ready = rst & sel_ifu_c;
  assign bus.lsu_req_ready = rst & sel_lsu_c;

  assign bus.mem_req_valid = (state_q == ARB_REQ_IFU) || (state_q == ARB_REQ_LSU);
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wen       = req_q.wen;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wmask     = req_q.wmask;

  assign bus.ifu_rsp_valid = in_wait_c & (owner_c == MST_IFU) & bus.mem_rsp_valid;
  assign bus.lsu_rsp_valid = in_wait_c & (owner_c == MST_LSU) & bus.mem_rsp_valid;
  assign bus.ifu_rsp_data  = (in_wait_c && owner_c == MST_IFU) ? bus.mem_rsp_data : '0;
  assign bus.lsu_rsp_data  = (in_wait_c && owner_c == MST_LSU && !req_q.wen) ?
                             bus.mem_rsp_data : '0;

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// Randomized transaction-level bench for the IFU/LSU memory arbiter.
module tb_ysyx_22040237_mem_arb;
  import ysyx_22040237_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040237_mem_arb_if bus();

  ysyx_22040237_mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last_lsu;   // model: LSU won the most recent grant

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".ifu_req_ready"}, 64'(bus.ifu_req_ready), 64'd0);
    check_eq({tag, ".lsu_req_ready"}, 64'(bus.lsu_req_ready), 64'd0);
    check_eq({tag, ".ifu_rsp_valid"}, 64'(bus.ifu_rsp_valid), 64'd0);
    check_eq({tag, ".lsu_rsp_valid"}, 64'(bus.lsu_rsp_valid), 64'd0);
    check_eq({tag, ".ifu_rsp_data"},  bus.ifu_rsp_data,       64'd0);
    check_eq({tag, ".lsu_rsp_data"},  bus.lsu_rsp_data,       64'd0);
    check_eq({tag, ".mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check_eq({tag, ".mem_addr"},      bus.mem_addr,           64'd0);
    check_eq({tag, ".mem_wen"},       64'(bus.mem_wen),       64'd0);
    check_eq({tag, ".mem_wdata"},     bus.mem_wdata,          64'd0);
    check_eq({tag, ".mem_wmask"},     64'(bus.mem_wmask),     64'd0);
  endtask

  // One complete transaction: offer requests, stall memory, then respond
  // (or assert reset in place of the response when abort is set).
  task automatic run_txn(input string tag, input bit iv, input bit lv,
                         input logic [63:0] ia, input logic [63:0] la, input bit wen,
                         input logic [63:0] wd, input logic [7:0] wm,
                         input int stall, input int delay, input logic [63:0] rd,
                         input bit abort);
    bit          exp_l, exp_i;
    logic [63:0] e_addr, e_wdata, e_rsp;
    bit          e_wen;
    logic [7:0]  e_wm;

    @(negedge clk);
    bus.ifu_req_valid = iv;  bus.ifu_addr = ia;
    bus.lsu_req_valid = lv;  bus.lsu_addr = la;
    bus.lsu_wen = wen;  bus.lsu_wdata = wd;  bus.lsu_wmask = wm;
    bus.mem_req_ready = 1'b0;  bus.mem_rsp_valid = 1'b0;  bus.mem_rsp_data = '0;
    #1;
    exp_l = lv && !(m_last_lsu && iv);
    exp_i = iv && !exp_l;
    check_eq({tag, ".ifu_req_ready"}, 64'(bus.ifu_req_ready), 64'(exp_i));
    check_eq({tag, ".lsu_req_ready"}, 64'(bus.lsu_req_ready), 64'(exp_l));
    if (!(exp_l || exp_i)) return;

    if (exp_l) begin
      e_addr = la;  e_wen = wen;  e_wdata = wd;  e_wm = wen ? wm : 8'h00;
      e_rsp  = wen ? 64'd0 : rd;
    end else begin
      e_addr = ia;  e_wen = 1'b0;  e_wdata = 64'd0;  e_wm = 8'h00;
      e_rsp  = rd;
    end
    m_last_lsu = exp_l;

    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      bus.mem_req_ready = (c == stall);
      bus.mem_rsp_valid = 1'($urandom_range(0, 1));
      bus.mem_rsp_data  = {$urandom, $urandom};
      #1;
      check_eq({tag, ".req.mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
      check_eq({tag, ".req.mem_addr"},      bus.mem_addr,           e_addr);
      check_eq({tag, ".req.mem_wen"},       64'(bus.mem_wen),       64'(e_wen));
      check_eq({tag, ".req.mem_wdata"},     bus.mem_wdata,          e_wdata);
      check_eq({tag, ".req.mem_wmask"},     64'(bus.mem_wmask),     64'(e_wm));
      check_eq({tag, ".req.readies"},
               64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
      check_eq({tag, ".req.rsp_valids"},
               64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    end

    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = (c == delay) && !abort;
      bus.mem_rsp_data  = (c == delay) ? rd : {$urandom, $urandom};
      if (c == delay && !abort) begin
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
      end
      #1;
      if (abort && c == delay) begin
        rst = 1'b0;
        #1;
        check_all_zero({tag, ".rst"});
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        m_last_lsu = 1'b0;
        return;
      end
      check_eq({tag, ".wait.mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
      check_eq({tag, ".wait.readies"},
               64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
      check_eq({tag, ".ifu_rsp_valid"}, 64'(bus.ifu_rsp_valid), 64'(exp_i && c == delay));
      check_eq({tag, ".lsu_rsp_valid"}, 64'(bus.lsu_rsp_valid), 64'(exp_l && c == delay));
      if (exp_i) begin
        check_eq({tag, ".lsu_rsp_data_idle"}, bus.lsu_rsp_data, 64'd0);
        if (c == delay) check_eq({tag, ".ifu_rsp_data"}, bus.ifu_rsp_data, e_rsp);
      end else begin
        check_eq({tag, ".ifu_rsp_data_idle"}, bus.ifu_rsp_data, 64'd0);
        if (c == delay) check_eq({tag, ".lsu_rsp_data"}, bus.lsu_rsp_data, e_rsp);
      end
    end
  endtask

  task automatic spurious_rsp();
    @(negedge clk);
    drive_idle();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hCAFE_F00D_0BAD_BEEF;
    #1;
    check_eq("spur.rsp_valids", 64'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 64'd0);
    check_eq("spur.ifu_rsp_data", bus.ifu_rsp_data, 64'd0);
    check_eq("spur.lsu_rsp_data", bus.lsu_rsp_data, 64'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    check_eq("spur.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
  endtask

  initial begin
    bit          iv, lv, wen;
    logic [63:0] wd;
    logic [7:0]  wm;

    rst = 1'b0;
    m_last_lsu = 1'b0;
    drive_idle();
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;

    run_txn("ifu_only", 1'b1, 1'b0, 64'h8000_0000, 64'd0, 1'b0, 64'd0, 8'h00,
            0, 0, 64'h0000_0013, 1'b0);
    run_txn("both_lsu", 1'b1, 1'b1, 64'h8000_0004, 64'h8000_1000, 1'b1,
            64'hDEAD_BEEF, 8'h0F, 0, 1, 64'h5555_AAAA, 1'b0);
    run_txn("both_ifu", 1'b1, 1'b1, 64'h8000_0004, 64'h8000_1000, 1'b1,
            64'hDEAD_BEEF, 8'h0F, 1, 0, 64'h0000_0093, 1'b0);
    run_txn("bp_store", 1'b0, 1'b1, 64'd0, 64'h8000_2008, 1'b1,
            64'h0123_4567_89AB_CDEF, 8'hF0, 4, 2, 64'h1, 1'b0);
    run_txn("load_mask", 1'b0, 1'b1, 64'd0, 64'h8000_3000, 1'b0,
            64'hFFFF_0000, 8'hFF, 0, 0, 64'h1234, 1'b0);
    spurious_rsp();
    run_txn("after_spur", 1'b1, 1'b0, 64'h8000_0010, 64'd0, 1'b0, 64'd0, 8'h00,
            0, 0, 64'h0000_0297, 1'b0);

    for (int i = 0; i < 40; i++) begin
      iv  = 1'($urandom_range(0, 1));
      lv  = 1'($urandom_range(0, 1));
      if (!iv && !lv) iv = 1'b1;
      wen = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      wm  = 8'($urandom);
      run_txn($sformatf("rand%0d", i), iv, lv, {32'd0, $urandom}, {32'd0, $urandom},
              wen, wd, wm, $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom}, 1'b0);
    end

    run_txn("abort_lsu", 1'b0, 1'b1, 64'd0, 64'h8000_4000, 1'b0, 64'd0, 8'h00,
            1, 2, 64'd0, 1'b1);
    run_txn("post_rst_both", 1'b1, 1'b1, 64'h8000_0020, 64'h8000_5000, 1'b0,
            64'd0, 8'h00, 0, 0, 64'h7777, 1'b0);
    run_txn("post_rst_ifu", 1'b1, 1'b0, 64'h8000_0024, 64'd0, 1'b0, 64'd0, 8'h00,
            0, 0, 64'h0000_0013, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
